// File: rtl/pkt_bank_buffer.sv
// Round-robin multi-bank packet buffer: samples a pixel bus into banks and serves one word per read request.
// Defining PKT_HEADER_EN prefixes every packet with a 4-word header generated from registers.
module pkt_bank_buffer #(
    parameter int                DATA_W   = 8,
    parameter int                PKT_SIZE = 4864,
    parameter int                N_BANKS  = 2,
    parameter logic [DATA_W-1:0] PAD_VAL  = '0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 pix_clk,
    input  logic                 frame_valid,
    input  logic                 line_valid,
    input  logic [DATA_W-1:0]    pix_data,
    input  logic                 rd_req,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 intr_out,
    output logic [15:0]          ovf_cnt,
    output logic [7:0]           frame_cnt,
    output logic [2*N_BANKS-1:0] bank_state_dbg
);
    localparam int AW = $clog2(PKT_SIZE);
    localparam int BW = $clog2(N_BANKS);
    localparam int PW = AW + 1;
    localparam int MW = $clog2(N_BANKS * PKT_SIZE);
`ifdef PKT_HEADER_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif
    localparam int PKT_LEN = PKT_SIZE + HDR;

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY, B_DRAINING} bank_st_e;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == BW'(N_BANKS - 1)) ? '0 : b + BW'(1);
    endfunction

    // Input synchroniser and edge detection
    logic [1:0]        pclk_s_q, fv_s_q, lv_s_q;
    logic [DATA_W-1:0] pix_s1_q, pix_s2_q, cap_data_q;
    logic              pclk_prev_q, fv_prev_q, cap_q, flush_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pclk_s_q    <= '0;
            fv_s_q      <= '0;
            lv_s_q      <= '0;
            pix_s1_q    <= '0;
            pix_s2_q    <= '0;
            pclk_prev_q <= 1'b0;
            fv_prev_q   <= 1'b0;
            cap_q       <= 1'b0;
            flush_q     <= 1'b0;
            cap_data_q  <= '0;
        end else begin
            pclk_s_q    <= {pclk_s_q[0], pix_clk};
            fv_s_q      <= {fv_s_q[0], frame_valid};
            lv_s_q      <= {lv_s_q[0], line_valid};
            pix_s1_q    <= pix_data;
            pix_s2_q    <= pix_s1_q;
            pclk_prev_q <= pclk_s_q[1];
            fv_prev_q   <= fv_s_q[1];
            cap_q       <= pclk_s_q[1] & ~pclk_prev_q & fv_s_q[1] & lv_s_q[1];
            flush_q     <= fv_prev_q & ~fv_s_q[1];
            cap_data_q  <= pix_s2_q;
        end
    end

    // Bank bookkeeping
    bank_st_e          st_q [N_BANKS];
    bank_st_e          st_d [N_BANKS];
    logic [PW-1:0]     fill_q [N_BANKS];
    logic [PW-1:0]     fill_d [N_BANKS];
    logic [BW-1:0]     wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, pidx;
    logic [15:0]       ovf_cnt_q, ovf_cnt_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              wr_en, rd_accept, rd_busy, rd_pad_d;
    logic [MW-1:0]     wr_addr, rd_addr;
    logic              rd_p1_q, rd_pad_q, rd_valid_q, intr_q;
    logic [DATA_W-1:0] ram_q, rd_data_q, rd_word;
`ifdef PKT_HEADER_EN
    logic [7:0]        hdr_frame_q [N_BANKS];
    logic [7:0]        hdr_frame_d [N_BANKS];
    logic [7:0]        hdr_idx_q [N_BANKS];
    logic [7:0]        hdr_idx_d [N_BANKS];
    logic              hdr_ovf_q [N_BANKS];
    logic              hdr_ovf_d [N_BANKS];
    logic              hdr_fs_q [N_BANKS];
    logic              hdr_fs_d [N_BANKS];
    logic [7:0]        pkt_idx_q, pkt_idx_d;
    logic              ovf_sticky_q, ovf_sticky_d;
    logic              rd_hdr_d, rd_hdr_q;
    logic [7:0]        rd_hdr_word_d;
    logic [7:0]        rd_hdr_word_q;
`endif

    // Read handshake: rd_req is a one-cycle strobe, accepted only while rd_bank is READY or
    // DRAINING and no earlier request is in flight; rd_valid then pulses exactly two cycles later.
    always_comb begin
        st_d        = st_q;
        fill_d      = fill_q;
        wr_bank_d   = wr_bank_q;
        wr_ptr_d    = wr_ptr_q;
        rd_bank_d   = rd_bank_q;
        rd_ptr_d    = rd_ptr_q;
        ovf_cnt_d   = ovf_cnt_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;
        rd_accept   = 1'b0;
        rd_busy     = rd_p1_q | rd_valid_q;
`ifdef PKT_HEADER_EN
        hdr_frame_d   = hdr_frame_q;
        hdr_idx_d     = hdr_idx_q;
        hdr_ovf_d     = hdr_ovf_q;
        hdr_fs_d      = hdr_fs_q;
        pkt_idx_d     = pkt_idx_q;
        ovf_sticky_d  = ovf_sticky_q;
        rd_hdr_d      = (rd_ptr_q < PW'(HDR));
        rd_hdr_word_d = 8'h00;
        case (rd_ptr_q[1:0])
            2'd0:    rd_hdr_word_d = 8'hA5;
            2'd1:    rd_hdr_word_d = hdr_frame_q[rd_bank_q];
            2'd2:    rd_hdr_word_d = hdr_idx_q[rd_bank_q];
            default: rd_hdr_word_d = {6'b0, hdr_ovf_q[rd_bank_q], hdr_fs_q[rd_bank_q]};
        endcase
        pidx = rd_hdr_d ? '0 : rd_ptr_q - PW'(HDR);
`else
        pidx = rd_ptr_q;
`endif
        rd_pad_d = (pidx >= fill_q[rd_bank_q]);
        rd_addr  = MW'(int'(rd_bank_q) * PKT_SIZE + int'(pidx[AW-1:0]));
        wr_addr  = MW'(int'(wr_bank_q) * PKT_SIZE + int'(wr_ptr_q));

        // Read side runs first so a bank freed this cycle can be re-entered by the write side.
        if (rd_req && !rd_busy &&
            (st_q[rd_bank_q] == B_READY || st_q[rd_bank_q] == B_DRAINING)) begin
            rd_accept       = 1'b1;
            st_d[rd_bank_q] = B_DRAINING;
            if (rd_ptr_q == PW'(PKT_LEN - 1)) begin
                st_d[rd_bank_q] = B_FREE;
                rd_bank_d       = next_bank(rd_bank_q);
                rd_ptr_d        = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end

        if (cap_q) begin
            if (st_d[wr_bank_q] == B_FREE || st_d[wr_bank_q] == B_FILLING) begin
                wr_en = 1'b1;
                if (st_d[wr_bank_q] == B_FREE) begin
                    st_d[wr_bank_q] = B_FILLING;
`ifdef PKT_HEADER_EN
                    hdr_frame_d[wr_bank_q] = frame_cnt_q;
                    hdr_idx_d[wr_bank_q]   = pkt_idx_q;
                    hdr_ovf_d[wr_bank_q]   = ovf_sticky_q;
                    hdr_fs_d[wr_bank_q]    = (pkt_idx_q == 8'd0);
                    ovf_sticky_d           = 1'b0;
`endif
                end
                if (wr_ptr_q == AW'(PKT_SIZE - 1)) begin
                    st_d[wr_bank_q]   = B_READY;
                    fill_d[wr_bank_q] = PW'(PKT_SIZE);
                    wr_bank_d         = next_bank(wr_bank_q);
                    wr_ptr_d          = '0;
`ifdef PKT_HEADER_EN
                    pkt_idx_d = pkt_idx_q + 8'd1;
`endif
                end else begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end else begin
                if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
`ifdef PKT_HEADER_EN
                ovf_sticky_d = 1'b1;
`endif
            end
        end

        // A capture and a frame-end never share a cycle: capture needs frame_valid high.
        if (flush_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (st_d[wr_bank_q] == B_FILLING) begin
                st_d[wr_bank_q]   = B_READY;
                fill_d[wr_bank_q] = {1'b0, wr_ptr_q};
                wr_bank_d         = next_bank(wr_bank_q);
                wr_ptr_d          = '0;
            end
`ifdef PKT_HEADER_EN
            pkt_idx_d = 8'd0;
`endif
        end

`ifdef PKT_HEADER_EN
        rd_word = rd_hdr_q ? DATA_W'(rd_hdr_word_q) : (rd_pad_q ? PAD_VAL : ram_q);
`else
        rd_word = rd_pad_q ? PAD_VAL : ram_q;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_BANKS; i++) begin
                st_q[i]   <= B_FREE;
                fill_q[i] <= '0;
`ifdef PKT_HEADER_EN
                hdr_frame_q[i] <= '0;
                hdr_idx_q[i]   <= '0;
                hdr_ovf_q[i]   <= 1'b0;
                hdr_fs_q[i]    <= 1'b0;
`endif
            end
            wr_bank_q   <= '0;
            wr_ptr_q    <= '0;
            rd_bank_q   <= '0;
            rd_ptr_q    <= '0;
            ovf_cnt_q   <= '0;
            frame_cnt_q <= '0;
            rd_p1_q     <= 1'b0;
            rd_pad_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            intr_q      <= 1'b0;
`ifdef PKT_HEADER_EN
            pkt_idx_q     <= '0;
            ovf_sticky_q  <= 1'b0;
            rd_hdr_q      <= 1'b0;
            rd_hdr_word_q <= '0;
`endif
        end else begin
            st_q        <= st_d;
            fill_q      <= fill_d;
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_bank_q   <= rd_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_cnt_q   <= ovf_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            rd_p1_q     <= rd_accept;
            if (rd_accept) rd_pad_q <= rd_pad_d;
            rd_valid_q  <= rd_p1_q;
            if (rd_p1_q) rd_data_q <= rd_word;
            intr_q      <= (st_q[rd_bank_q] == B_READY);
`ifdef PKT_HEADER_EN
            hdr_frame_q  <= hdr_frame_d;
            hdr_idx_q    <= hdr_idx_d;
            hdr_ovf_q    <= hdr_ovf_d;
            hdr_fs_q     <= hdr_fs_d;
            pkt_idx_q    <= pkt_idx_d;
            ovf_sticky_q <= ovf_sticky_d;
            if (rd_accept) begin
                rd_hdr_q      <= rd_hdr_d;
                rd_hdr_word_q <= rd_hdr_word_d;
            end
`endif
        end
    end

    // Packet storage: contents survive reset
    logic [DATA_W-1:0] mem [N_BANKS*PKT_SIZE];

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_addr] <= cap_data_q;
        if (rd_accept) ram_q <= mem[rd_addr];
    end

    always_comb begin
        bank_state_dbg = '0;
        for (int i = 0; i < N_BANKS; i++) bank_state_dbg[2*i +: 2] = st_q[i];
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign intr_out  = intr_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign frame_cnt = frame_cnt_q;
endmodule
